test_sink: RTL and testbench

Synthesizable receive-side test harness block: accepts a stream of messages over a val/rdy interface, compares each against a preloaded expected-message table, and reports pass/fail. It sits at the output end of a DUT in processor and memory test benches. It complements the stimulus side of the bench and can insert pseudo-random backpressure, so benches exercise stall paths without hand-written delays.

---
 rtl/test_sink_pkg.sv | 24 ++
 rtl/test_lfsr.sv | 37 +++
 rtl/test_sink.sv | 165 ++++++++++++++++
 tb/tb_test_sink.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_sink_pkg.sv
// Shared types and constants for the receive-side test sink and its LFSR.
package test_sink_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_SEED = 32'hdeadbeef;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Right-shifting Galois step: the bit shifted out folds the tap mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] shifted;
        shifted = {1'b0, cur[31:1]};
        if (cur[0]) begin
            lfsr_next = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_next = shifted;
        end
    endfunction

endpackage

// File: rtl/test_lfsr.sv
// 32-bit Galois LFSR that advances only when enabled; exposes its low bits.
module test_lfsr
    import test_sink_pkg::*;
#(
    parameter int p_out_bits = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic [p_out_bits-1:0] lfsr_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next-state: step only on enable so the sequence is tied to events, not time.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State register, reset to the fixed seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[p_out_bits-1:0];

endmodule

// File: rtl/test_sink.sv
// Receive-side test sink: checks an incoming val/rdy stream against a preloaded
// table, counts mismatches and optionally inserts pseudo-random backpressure.
module test_sink
    import test_sink_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_num_msgs  = 16,
    parameter int p_max_delay = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic [$clog2(p_num_msgs)-1:0]   load_idx,
    input  logic [p_nbits-1:0]              load_msg,
    input  logic [$clog2(p_num_msgs+1)-1:0] num_msgs,
    input  logic                            start,
    input  logic                            recv_val,
    output logic                            recv_rdy,
    input  logic [p_nbits-1:0]              recv_msg,
    output logic                            done,
    output logic [$clog2(p_num_msgs+1)-1:0] num_errors,
    output logic [$clog2(p_num_msgs)-1:0]   first_err_idx
);

    localparam int IW = $clog2(p_num_msgs);
    localparam int CW = $clog2(p_num_msgs + 1);
    localparam int K  = $clog2(p_max_delay + 1);
    localparam int DW = (K > 0) ? K : 1;

    localparam logic [CW-1:0] CW_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CW_ONE  = CW'(1'b1);
    localparam logic [DW-1:0] DW_ZERO = DW'(1'b0);
    localparam logic [DW-1:0] DW_ONE  = DW'(1'b1);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     nerr_q, nerr_d;
    logic [IW-1:0]     ferr_q, ferr_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [p_nbits-1:0] table_q [p_num_msgs];

    logic [DW-1:0]      lfsr_s;
    logic [DW-1:0]      delay_load_s;
    logic [CW-1:0]      idx_inc_s;
    logic [p_nbits-1:0] exp_msg_s;
    logic               rdy_s;
    logic               done_s;
    logic               xfer_s;
    logic               mismatch_s;

    test_lfsr #(
        .p_out_bits (DW)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (xfer_s),
        .lfsr_o (lfsr_s)
    );

    generate
        if (K > 0) begin : g_delay
            assign delay_load_s = lfsr_s;
        end else begin : g_no_delay
            assign delay_load_s = DW_ZERO;
        end
    endgenerate

    assign idx_inc_s  = idx_q + CW_ONE;
    assign exp_msg_s  = table_q[idx_q[IW-1:0]];
    assign mismatch_s = (recv_msg !== exp_msg_s);
    assign xfer_s     = recv_val && rdy_s;

    // Expected-message table: deliberately not reset so a bench can rerun without reloading.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == ST_LOAD)) begin
            table_q[load_idx] <= load_msg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            count_q <= CW_ZERO;
            idx_q   <= CW_ZERO;
            nerr_q  <= CW_ZERO;
            ferr_q  <= IW'(1'b0);
            delay_q <= DW_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            nerr_q  <= nerr_d;
            ferr_q  <= ferr_d;
            delay_q <= delay_d;
        end
    end

    // Next-state logic for the LOAD/RUN/DONE sequence and per-transfer bookkeeping.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        nerr_d  = nerr_q;
        ferr_d  = ferr_q;
        delay_d = delay_q;
        case (state_q)
            ST_LOAD: begin
                delay_d = DW_ZERO;
                if (start) begin
                    count_d = num_msgs;
                    idx_d   = CW_ZERO;
                    nerr_d  = CW_ZERO;
                    ferr_d  = IW'(1'b0);
                    state_d = (num_msgs == CW_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    idx_d   = idx_inc_s;
                    delay_d = delay_load_s;
                    if (mismatch_s) begin
                        nerr_d = nerr_q + CW_ONE;
                        ferr_d = (nerr_q == CW_ZERO) ? idx_q[IW-1:0] : ferr_q;
                    end else begin
                        nerr_d = nerr_q;
                        ferr_d = ferr_q;
                    end
                    state_d = (idx_inc_s == count_q) ? ST_DONE : ST_RUN;
                end else if (delay_q != DW_ZERO) begin
                    delay_d = delay_q - DW_ONE;
                end else begin
                    delay_d = delay_q;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Outputs decode from registered state only, never from recv_val.
    always_comb begin
        rdy_s  = 1'b0;
        done_s = 1'b0;
        if (state_q == ST_RUN) begin
            rdy_s = (delay_q == DW_ZERO) && (idx_q < count_q);
        end else begin
            rdy_s = 1'b0;
        end
        done_s = (state_q == ST_DONE);
    end

    assign recv_rdy      = rdy_s;
    assign done          = done_s;
    assign num_errors    = nerr_q;
    assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_test_sink.sv
// Self-checking bench for test_sink: one instance without and one with backpressure.
module tb_test_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_idx = 4'd0;
    logic [31:0] load_msg = 32'd0;
    logic [4:0]  num_msgs = 5'd0;
    logic        start = 1'b0;
    logic        recv_val = 1'b0;
    logic [31:0] recv_msg = 32'd0;

    logic        rdy0, done0, rdy3, done3;
    logic [4:0]  nerr0, nerr3;
    logic [3:0]  ferr0, ferr3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0][31:0] send;
        logic [4:0]       errs;
        logic [3:0]       first;
    } vec_t;

    typedef struct {
        logic [4:0] errs;
        logic [3:0] first;
    } res_t;

    vec_t        vecs [5];
    res_t        sb_q [$];
    logic [31:0] ref_tbl [8];
    int          gaps [2][8];

    test_sink #(.p_nbits(32), .p_num_msgs(16), .p_max_delay(0)) u_dut0 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_msg(load_msg),
        .num_msgs(num_msgs), .start(start), .recv_val(recv_val), .recv_rdy(rdy0),
        .recv_msg(recv_msg), .done(done0), .num_errors(nerr0), .first_err_idx(ferr0)
    );

    test_sink #(.p_nbits(32), .p_num_msgs(16), .p_max_delay(3)) u_dut3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_msg(load_msg),
        .num_msgs(num_msgs), .start(start), .recv_val(recv_val), .recv_rdy(rdy3),
        .recv_msg(recv_msg), .done(done3), .num_errors(nerr3), .first_err_idx(ferr3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [4:0] e, input logic [3:0] f);
        vec_t v;
        v.send[0] = a;
        v.send[1] = b;
        v.send[2] = c;
        v.errs    = e;
        v.first   = f;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; load_en = 1'b0; start = 1'b0; recv_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_idx = 4'(i); load_msg = ref_tbl[i];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Returns at the negedge following the start edge.
    task automatic start_run(input int n);
        num_msgs = 5'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_done(input logic d, input logic r, input logic [4:0] e, input logic [3:0] f);
        res_t exp;
        check("done_high", {31'd0, d}, 32'd1);
        check("rdy_low_in_done", {31'd0, r}, 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check("num_errors", {27'd0, e}, {27'd0, exp.errs});
            if (exp.errs != 5'd0) check("first_err_idx", {28'd0, f}, {28'd0, exp.first});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int merr;
        do_reset();
        load_n(3);
        start_run(3);
        sb_q.push_back('{v.errs, v.first});
        merr = 0;
        for (int k = 0; k < 3; k++) begin
            check("rdy_back_to_back", {31'd0, rdy0}, 32'd1);
            check("done_not_early", {31'd0, done0}, 32'd0);
            recv_val = 1'b1; recv_msg = v.send[k];
            @(negedge clk);
            if (v.send[k] !== ref_tbl[k]) merr++;
            check("errors_next_cycle", {27'd0, nerr0}, 32'(merr));
        end
        recv_val = 1'b0;
        check_done(done0, rdy0, nerr0, ferr0);
    endtask

    task automatic run_delay(input int r);
        int sent, gap, cyc;
        do_reset();
        load_n(8);
        start_run(8);
        sb_q.push_back('{5'd0, 4'd0});
        sent = 0; gap = 0; cyc = 0;
        recv_val = 1'b1;
        while (sent < 8 && cyc < 200) begin
            recv_msg = ref_tbl[sent];
            if (rdy3) begin
                gaps[r][sent] = gap;
                check("gap_within_max", (gap <= 3) ? 32'd1 : 32'd0, 32'd1);
                gap = 0;
                sent++;
            end else begin
                gap++;
            end
            @(negedge clk);
            cyc++;
        end
        recv_val = 1'b0;
        check("delay_all_accepted", 32'(sent), 32'd8);
        check_done(done3, rdy3, nerr3, ferr3);
    endtask

    initial begin
        int seen_rdy, gap_sum;

        ref_tbl[0] = 32'h11; ref_tbl[1] = 32'h22; ref_tbl[2] = 32'h33;
        vecs[0] = mk(32'h11, 32'h22, 32'h33, 5'd0, 4'd0);
        vecs[1] = mk(32'h11, 32'h99, 32'h33, 5'd1, 4'd1);
        vecs[2] = mk(32'h00, 32'h00, 32'h00, 5'd3, 4'd0);
        vecs[3] = mk(32'h11, 32'h22, 32'h34, 5'd1, 4'd2);
        vecs[4] = mk(32'h10, 32'h22, 32'h34, 5'd2, 4'd0);

        // Reset values.
        do_reset();
        check("reset_rdy", {31'd0, rdy0}, 32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        check("reset_errors", {27'd0, nerr0}, 32'd0);
        check("reset_first", {28'd0, ferr0}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Zero-length run goes straight to DONE with no ready.
        do_reset();
        start_run(0);
        check("zero_done", {31'd0, done0}, 32'd1);
        seen_rdy = 0;
        recv_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rdy0) seen_rdy++;
            @(negedge clk);
        end
        recv_val = 1'b0;
        check("zero_never_ready", 32'(seen_rdy), 32'd0);
        check("zero_done_sticky", {31'd0, done0}, 32'd1);

        // Backpressure runs, repeated from reset for reproducibility.
        for (int i = 0; i < 8; i++) ref_tbl[i] = 32'hA5A5_0000 + 32'(i * 7);
        run_delay(0);
        run_delay(1);
        gap_sum = 0;
        for (int i = 0; i < 8; i++) begin
            check("gap_repeatable", 32'(gaps[1][i]), 32'(gaps[0][i]));
            gap_sum += gaps[0][i];
        end
        check("backpressure_present", (gap_sum > 0) ? 32'd1 : 32'd0, 32'd1);

        // Reset mid-run; the last entry is written in the same cycle as start.
        ref_tbl[0] = 32'h11; ref_tbl[1] = 32'h22; ref_tbl[2] = 32'h33; ref_tbl[3] = 32'h44;
        do_reset();
        load_n(3);
        load_en = 1'b1; load_idx = 4'd3; load_msg = ref_tbl[3];
        num_msgs = 5'd4; start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        recv_val = 1'b1; recv_msg = 32'h11;
        @(negedge clk);
        recv_msg = 32'hBAD;
        @(negedge clk);
        recv_val = 1'b0;
        check("midrun_errors", {27'd0, nerr0}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_rdy", {31'd0, rdy0}, 32'd0);
        check("async_reset_done", {31'd0, done0}, 32'd0);
        check("async_reset_errors", {27'd0, nerr0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_run(4);
        sb_q.push_back('{5'd0, 4'd0});
        for (int k = 0; k < 4; k++) begin
            check("restart_rdy", {31'd0, rdy0}, 32'd1);
            recv_val = 1'b1; recv_msg = ref_tbl[k];
            @(negedge clk);
        end
        recv_val = 1'b0;
        check_done(done0, rdy0, nerr0, ferr0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
